// File: rtl/nox_boot_loader.sv
// UART-to-AXI boot loader: receives a length-prefixed image over UART and
// writes it word by word into IRAM, then releases the core to fetch.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for MMCM lock; UART bytes are dropped
// ST_LEN   | collecting the 4-byte little-endian image length
// ST_CHECK | validating the length (one cycle)
// ST_DATA  | packing 4 image bytes into the next word
// ST_WR    | AW/W channels open, each valid held until its ready
// ST_RESP  | waiting for the B response
// ST_DONE  | image written, start_fetch_o held high
// ST_ERR   | image or link error, boot_err_o held high

package utils_pkg;
  typedef struct packed {
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } s_axi_miso_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam logic [1:0] AXI_INCR = 2'b01;
endpackage

module nox_boot_loader
  import utils_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 1736,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          MAX_BYTES    = 65536
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        locked_i,
  input  logic        uart_rx_i,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i,
  output logic        start_fetch_o,
  output logic        boot_err_o,
  output logic        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_CHECK, ST_DATA, ST_WR, ST_RESP, ST_DONE, ST_ERR
  } st_e;

  logic lock_meta_q, lock_q, rx_meta_q, rx_q, rx_prev_q;

  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_vld, frame_err;

  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       pop, overrun, link_err;

  st_e         st_q, st_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d, addr_q, addr_d, rem_q, rem_d, word_q, word_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        pend_err_q, pend_err_d, pend_unlock_q, pend_unlock_d;
  logic        start_q, start_d, err_q, err_d;
  logic        aw_hs, w_hs;
  logic        unused_miso;

  // Two-stage synchronisers for the asynchronous lock and UART inputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      lock_meta_q <= 1'b0;
      lock_q      <= 1'b0;
      rx_meta_q   <= 1'b1;
      rx_q        <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      lock_meta_q <= locked_i;
      lock_q      <= lock_meta_q;
      rx_meta_q   <= uart_rx_i;
      rx_q        <= rx_meta_q;
      rx_prev_q   <= rx_q;
    end
  end

  // UART receiver: start edge, mid-bit sampling via a down-counter, stop check.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld   = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = HALF_BIT;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_q) begin
            rx_st_d = RX_IDLE;
          end else begin
            rx_st_d  = RX_DATA;
            rx_cnt_d = FULL_BIT;
            rx_bit_d = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_q, rx_shift_q[7:1]};
          rx_cnt_d   = FULL_BIT;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_st_d   = RX_IDLE;
          byte_vld  = rx_q;
          frame_err = !rx_q;
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Bytes are consumed (or dropped) only in states that can accept them.
  assign pop      = hold_full_q && (st_q inside {ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR});
  assign overrun  = byte_vld && hold_full_q && !pop;
  assign link_err = frame_err || overrun;

  // One-byte holding register between the receiver and the FSM.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (pop) hold_full_d = 1'b0;
    if (byte_vld) begin
      hold_full_d = 1'b1;
      hold_data_d = rx_shift_q;
    end
  end

  assign aw_hs = awvalid_q && axi_miso_i.awready;
  assign w_hs  = wvalid_q && axi_miso_i.wready;

  // Boot FSM next-state and datapath.
  always_comb begin
    st_d          = st_q;
    byte_cnt_d    = byte_cnt_q;
    len_d         = len_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    word_d        = word_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    pend_err_d    = pend_err_q;
    pend_unlock_d = pend_unlock_q;
    start_d       = start_q;
    err_d         = err_q;
    case (st_q)
      ST_IDLE: begin
        if (link_err) st_d = ST_ERR;
        else if (lock_q) begin
          st_d       = ST_LEN;
          byte_cnt_d = 2'd0;
        end
      end
      ST_LEN, ST_DATA: begin
        if (link_err) st_d = ST_ERR;
        else if (!lock_q) begin
          st_d       = ST_IDLE;
          byte_cnt_d = 2'd0;
        end else if (pop) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (st_q == ST_LEN) len_d = {hold_data_q, len_q[31:8]};
          else word_d = {hold_data_q, word_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            if (st_q == ST_LEN) begin
              st_d = ST_CHECK;
            end else begin
              st_d          = ST_WR;
              awvalid_d     = 1'b1;
              wvalid_d      = 1'b1;
              aw_done_d     = 1'b0;
              w_done_d      = 1'b0;
              pend_err_d    = 1'b0;
              pend_unlock_d = 1'b0;
            end
          end
        end
      end
      ST_CHECK: begin
        if (link_err) st_d = ST_ERR;
        else if (!lock_q) st_d = ST_IDLE;
        else if (len_q == 32'd0) st_d = ST_DONE;
        else if (len_q > 32'(MAX_BYTES) || len_q[1:0] != 2'b00) st_d = ST_ERR;
        else begin
          st_d       = ST_DATA;
          addr_d     = BASE_ADDR;
          rem_d      = len_q;
          byte_cnt_d = 2'd0;
        end
      end
      ST_WR: begin
        pend_err_d    = pend_err_q || link_err;
        pend_unlock_d = pend_unlock_q || !lock_q;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          st_d     = ST_RESP;
          bready_d = 1'b1;
        end
      end
      ST_RESP: begin
        pend_err_d    = pend_err_q || link_err;
        pend_unlock_d = pend_unlock_q || !lock_q;
        if (bready_q && axi_miso_i.bvalid) begin
          bready_d = 1'b0;
          if (axi_miso_i.bresp != AXI_OKAY || pend_err_q || link_err) begin
            st_d = ST_ERR;
          end else begin
            addr_d     = addr_q + 32'd4;
            rem_d      = rem_q - 32'd4;
            byte_cnt_d = 2'd0;
            if (rem_q == 32'd4) st_d = ST_DONE;
            else if (pend_unlock_q || !lock_q) st_d = ST_IDLE;
            else st_d = ST_DATA;
          end
        end
      end
      default: st_d = st_q;
    endcase
    if (st_d == ST_DONE) start_d = 1'b1;
    if (st_d == ST_ERR) err_d = 1'b1;
  end

  // All FSM, receiver and AXI-facing registers.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      rx_st_q       <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'd0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= 8'd0;
      st_q          <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      len_q         <= 32'd0;
      addr_q        <= 32'd0;
      rem_q         <= 32'd0;
      word_q        <= 32'd0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      pend_err_q    <= 1'b0;
      pend_unlock_q <= 1'b0;
      start_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rx_st_q       <= rx_st_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      st_q          <= st_d;
      byte_cnt_q    <= byte_cnt_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      word_q        <= word_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      pend_err_q    <= pend_err_d;
      pend_unlock_q <= pend_unlock_d;
      start_q       <= start_d;
      err_q         <= err_d;
    end
  end

  // AXI outputs come only from registers or constants; read channel is parked.
  always_comb begin
    axi_mosi_o         = '0;
    axi_mosi_o.awaddr  = addr_q;
    axi_mosi_o.awsize  = 3'd2;
    axi_mosi_o.awburst = AXI_INCR;
    axi_mosi_o.awvalid = awvalid_q;
    axi_mosi_o.wdata   = word_q;
    axi_mosi_o.wstrb   = 4'hF;
    axi_mosi_o.wlast   = 1'b1;
    axi_mosi_o.wvalid  = wvalid_q;
    axi_mosi_o.bready  = bready_q;
    axi_mosi_o.rready  = 1'b1;
  end

  assign start_fetch_o = start_q;
  assign boot_err_o    = err_q;
  assign busy_o        = !(st_q inside {ST_IDLE, ST_DONE, ST_ERR});

  assign unused_miso = ^{axi_miso_i.bid, axi_miso_i.arready, axi_miso_i.rid,
                         axi_miso_i.rdata, axi_miso_i.rresp, axi_miso_i.rlast,
                         axi_miso_i.rvalid};

endmodule

// File: tb/tb_nox_boot_loader.sv
// Directed bench for nox_boot_loader with a configurable-latency AXI slave.
module tb_nox_boot_loader;
  import utils_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic arst = 1'b0;
  logic locked = 1'b0;
  logic uart_rx = 1'b1;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic start_fetch, boot_err, busy;

  int checks = 0;
  int errors = 0;

  int aw_delay = 0, w_delay = 0, b_delay = 0, slverr_idx = -1;
  int aw_count, w_count, b_count;
  logic [31:0] rec_addr [16];
  logic [31:0] rec_data [16];
  logic [3:0]  rec_strb [16];
  logic [7:0]  rec_len  [16];
  logic [2:0]  rec_size [16];
  logic [1:0]  rec_burst[16];
  logic        rec_last [16];

  always #5 clk = ~clk;

  nox_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .arst(arst), .locked_i(locked), .uart_rx_i(uart_rx),
    .axi_mosi_o(mosi), .axi_miso_i(miso),
    .start_fetch_o(start_fetch), .boot_err_o(boot_err), .busy_o(busy)
  );

  // AXI slave: readies and B after programmable delays, checks valid stability.
  initial begin : slave
    int aw_wait, w_wait, b_wait;
    bit aw_pend, w_pend, aw_acc, w_acc;
    logic [31:0] aw_hold, w_hold;
    miso = '0;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    aw_pend = 0; w_pend = 0; aw_acc = 0; w_acc = 0;
    aw_hold = '0; w_hold = '0;
    aw_count = 0; w_count = 0; b_count = 0;
    forever begin
      @(negedge clk);
      miso.awready = 1'b0;
      miso.wready  = 1'b0;
      miso.bvalid  = 1'b0;
      miso.bresp   = 2'b00;
      if (!arst) begin
        aw_count = 0; w_count = 0; b_count = 0;
        aw_pend = 0; w_pend = 0; aw_acc = 0; w_acc = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0;
      end else begin
        if (aw_acc) begin
          checks++;
          if (mosi.awvalid !== 1'b0) begin errors++; $display("FAIL aw_drop awvalid=%0b after accept, want 0", mosi.awvalid); end
        end
        if (w_acc) begin
          checks++;
          if (mosi.wvalid !== 1'b0) begin errors++; $display("FAIL w_drop wvalid=%0b after accept, want 0", mosi.wvalid); end
        end
        if (mosi.awvalid && !aw_acc) begin
          if (aw_pend) begin
            checks++;
            if (mosi.awaddr !== aw_hold) begin errors++; $display("FAIL aw_stable awaddr=%h want %h", mosi.awaddr, aw_hold); end
          end else begin
            aw_pend = 1; aw_wait = 0; aw_hold = mosi.awaddr;
          end
          if (aw_wait >= aw_delay) begin
            miso.awready = 1'b1;
            rec_addr[aw_count[3:0]]  = mosi.awaddr;
            rec_len[aw_count[3:0]]   = mosi.awlen;
            rec_size[aw_count[3:0]]  = mosi.awsize;
            rec_burst[aw_count[3:0]] = mosi.awburst;
            aw_count++; aw_acc = 1; aw_pend = 0;
          end else aw_wait++;
        end else if (aw_pend) begin
          checks++; errors++; aw_pend = 0;
          $display("FAIL aw_hold awvalid=0 before awready, want 1");
        end
        if (mosi.wvalid && !w_acc) begin
          if (w_pend) begin
            checks++;
            if (mosi.wdata !== w_hold) begin errors++; $display("FAIL w_stable wdata=%h want %h", mosi.wdata, w_hold); end
          end else begin
            w_pend = 1; w_wait = 0; w_hold = mosi.wdata;
          end
          if (w_wait >= w_delay) begin
            miso.wready = 1'b1;
            rec_data[w_count[3:0]] = mosi.wdata;
            rec_strb[w_count[3:0]] = mosi.wstrb;
            rec_last[w_count[3:0]] = mosi.wlast;
            w_count++; w_acc = 1; w_pend = 0;
          end else w_wait++;
        end else if (w_pend) begin
          checks++; errors++; w_pend = 0;
          $display("FAIL w_hold wvalid=0 before wready, want 1");
        end
        if (aw_acc && w_acc && mosi.bready) begin
          if (b_wait >= b_delay) begin
            miso.bvalid = 1'b1;
            miso.bresp  = (b_count == slverr_idx) ? 2'b10 : 2'b00;
            b_count++; aw_acc = 0; w_acc = 0; b_wait = 0;
          end else b_wait++;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    arst = 1'b0; locked = 1'b0; uart_rx = 1'b1;
    aw_delay = 0; w_delay = 0; b_delay = 0; slverr_idx = -1;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
  endtask

  task automatic lock_up();
    locked = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_len(input logic [31:0] v);
    send_byte(v[7:0], 1'b0);
    send_byte(v[15:8], 1'b0);
    send_byte(v[23:16], 1'b0);
    send_byte(v[31:24], 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (start_fetch !== 1'b0) begin errors++; $display("FAIL rst_start got %0b want 0", start_fetch); end
    checks++; if (boot_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", boot_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if ({mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid} !== 4'b0000) begin
      errors++; $display("FAIL rst_valids got %b want 0000", {mosi.awvalid, mosi.wvalid, mosi.bready, mosi.arvalid}); end
    checks++; if (mosi.rready !== 1'b1) begin errors++; $display("FAIL rst_rready got %0b want 1", mosi.rready); end
    @(negedge clk);
    locked = 1'b1;
    @(negedge clk); @(negedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_lat2 busy got %0b want 0", busy); end
    @(negedge clk); #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_lat3 busy got %0b want 1", busy); end
  endtask

  task automatic test_image_load();
    logic [7:0] img [8];
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    lock_up();
    send_len(32'd8);
    fork
      for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
      begin
        int n;
        n = 0;
        while (b_count < 2 && n < 3000) begin @(negedge clk); #2; n++; end
        checks++;
        if (b_count < 2) begin errors++; $display("FAIL load_b_timeout b_count=%0d want 2", b_count); end
        else begin
          checks++; if (start_fetch !== 1'b0) begin errors++; $display("FAIL load_start_early got %0b want 0", start_fetch); end
          @(negedge clk); #2;
          checks++; if (start_fetch !== 1'b1) begin errors++; $display("FAIL load_start_rise got %0b want 1", start_fetch); end
        end
      end
    join
    settle(5);
    checks++; if (aw_count !== 2) begin errors++; $display("FAIL load_aw_count got %0d want 2", aw_count); end
    checks++; if (w_count !== 2) begin errors++; $display("FAIL load_w_count got %0d want 2", w_count); end
    checks++; if (rec_addr[0] !== 32'h8000_0000) begin errors++; $display("FAIL load_addr0 got %h want 80000000", rec_addr[0]); end
    checks++; if (rec_data[0] !== 32'h4433_2211) begin errors++; $display("FAIL load_data0 got %h want 44332211", rec_data[0]); end
    checks++; if (rec_addr[1] !== 32'h8000_0004) begin errors++; $display("FAIL load_addr1 got %h want 80000004", rec_addr[1]); end
    checks++; if (rec_data[1] !== 32'h8877_6655) begin errors++; $display("FAIL load_data1 got %h want 88776655", rec_data[1]); end
    checks++; if ({rec_strb[0], rec_strb[1]} !== 8'hFF) begin errors++; $display("FAIL load_strb got %h%h want FF", rec_strb[0], rec_strb[1]); end
    checks++; if ({rec_len[0], rec_size[0], rec_burst[0], rec_last[0]} !== {8'd0, 3'd2, 2'b01, 1'b1}) begin
      errors++; $display("FAIL load_attr len=%0d size=%0d burst=%0d last=%0b want 0 2 1 1", rec_len[0], rec_size[0], rec_burst[0], rec_last[0]); end
    checks++; if (boot_err !== 1'b0) begin errors++; $display("FAIL load_err got %0b want 0", boot_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] img [8];
    img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    do_reset();
    aw_delay = 5; w_delay = 2; b_delay = 7;
    lock_up();
    send_len(32'd8);
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
    settle(60);
    checks++; if (aw_count !== 2 || w_count !== 2 || b_count !== 2) begin
      errors++; $display("FAIL bp_counts aw=%0d w=%0d b=%0d want 2 2 2", aw_count, w_count, b_count); end
    checks++; if (rec_data[0] !== 32'hD4C3_B2A1) begin errors++; $display("FAIL bp_data0 got %h want D4C3B2A1", rec_data[0]); end
    checks++; if (rec_data[1] !== 32'h1807_F6E5) begin errors++; $display("FAIL bp_data1 got %h want 1807F6E5", rec_data[1]); end
    checks++; if (rec_addr[1] !== 32'h8000_0004) begin errors++; $display("FAIL bp_addr1 got %h want 80000004", rec_addr[1]); end
    checks++; if ({start_fetch, boot_err} !== 2'b10) begin errors++; $display("FAIL bp_status start/err got %b want 10", {start_fetch, boot_err}); end
  endtask

  task automatic test_len_errors();
    logic [31:0] lens [2];
    lens = '{32'd6, 32'd65540};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      lock_up();
      send_len(lens[k]);
      settle(20);
      checks++; if (boot_err !== 1'b1) begin errors++; $display("FAIL lenerr_err len=%0d got %0b want 1", lens[k], boot_err); end
      checks++; if (start_fetch !== 1'b0) begin errors++; $display("FAIL lenerr_start len=%0d got %0b want 0", lens[k], start_fetch); end
      checks++; if (aw_count !== 0) begin errors++; $display("FAIL lenerr_aw len=%0d got %0d want 0", lens[k], aw_count); end
    end
  endtask

  task automatic test_link_errors();
    logic [7:0] img [8];
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    lock_up();
    send_len(32'd8);
    for (int i = 0; i < 8; i++) send_byte(img[i], i == 2);
    settle(20);
    checks++; if (boot_err !== 1'b1) begin errors++; $display("FAIL frame_err got %0b want 1", boot_err); end
    checks++; if (aw_count !== 0 || start_fetch !== 1'b0) begin
      errors++; $display("FAIL frame_noaw aw=%0d start=%0b want 0 0", aw_count, start_fetch); end
    do_reset();
    slverr_idx = 1;
    lock_up();
    send_len(32'd12);
    for (int i = 0; i < 12; i++) send_byte(8'(i + 1), 1'b0);
    settle(30);
    checks++; if (boot_err !== 1'b1) begin errors++; $display("FAIL slverr_err got %0b want 1", boot_err); end
    checks++; if (aw_count !== 2 || start_fetch !== 1'b0) begin
      errors++; $display("FAIL slverr_noaw aw=%0d start=%0b want 2 0", aw_count, start_fetch); end
  endtask

  task automatic test_lock_loss();
    do_reset();
    lock_up();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    locked = 1'b0;
    settle(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unlock_idle busy got %0b want 0", busy); end
    locked = 1'b1;
    settle(10);
    send_len(32'd4);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
    settle(20);
    checks++; if (aw_count !== 1) begin errors++; $display("FAIL relock_aw got %0d want 1", aw_count); end
    checks++; if (rec_addr[0] !== 32'h8000_0000 || rec_data[0] !== 32'hEFBE_ADDE) begin
      errors++; $display("FAIL relock_write got %h<-%h want 80000000<-EFBEADDE", rec_addr[0], rec_data[0]); end
    checks++; if ({start_fetch, boot_err} !== 2'b10) begin errors++; $display("FAIL relock_status got %b want 10", {start_fetch, boot_err}); end
  endtask

  task automatic test_reset_mid_resp();
    int n;
    do_reset();
    b_delay = 200;
    lock_up();
    send_len(32'd4);
    for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b0);
    n = 0;
    while (!mosi.bready && n < 200) begin @(negedge clk); #2; n++; end
    checks++; if (mosi.bready !== 1'b1) begin errors++; $display("FAIL resp_reach bready got %0b want 1", mosi.bready); end
    arst = 1'b0;
    #1;
    checks++; if ({mosi.awvalid, mosi.wvalid, mosi.bready, busy, start_fetch, boot_err} !== 6'b0) begin
      errors++; $display("FAIL arst_async got %b want 000000", {mosi.awvalid, mosi.wvalid, mosi.bready, busy, start_fetch, boot_err}); end
    checks++; if (mosi.rready !== 1'b1) begin errors++; $display("FAIL arst_rready got %0b want 1", mosi.rready); end
    @(negedge clk);
    arst = 1'b1;
  endtask

  task automatic test_empty();
    bit found, prev_start;
    do_reset();
    lock_up();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    found = 0;
    prev_start = start_fetch;
    fork
      send_byte(8'h00, 1'b0);
      for (int i = 0; i < 400 && !found; i++) begin
        @(negedge clk); #2;
        if (!busy) found = 1;
        else prev_start = start_fetch;
      end
    join
    checks++; if (!found) begin errors++; $display("FAIL empty_timeout busy still 1, want 0"); end
    checks++; if ({prev_start, start_fetch} !== 2'b01) begin
      errors++; $display("FAIL empty_rise start before/after got %b want 01", {prev_start, start_fetch}); end
    settle(20);
    checks++; if (aw_count !== 0 || w_count !== 0) begin errors++; $display("FAIL empty_axi aw=%0d w=%0d want 0 0", aw_count, w_count); end
    checks++; if ({start_fetch, boot_err} !== 2'b10) begin errors++; $display("FAIL empty_sticky got %b want 10", {start_fetch, boot_err}); end
  endtask

  initial begin
    test_reset();
    test_image_load();
    test_backpressure();
    test_len_errors();
    test_link_errors();
    test_lock_loss();
    test_reset_mid_resp();
    test_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
